bus_event_peripheral: RTL

Parametrised, memory-mapped event peripheral on the processor's 8-bit bus: the successor to the single-snapshot mouse register window. It captures multi-byte event records from a source (mouse transceiver, IR receiver, etc.) into a DEPTH-entry FIFO instead of overwriting a single snapshot. It exposes the head record, a status byte and a control byte to the CPU, and raises a thresholded, acknowledged interrupt. Sits between a source transceiver and the shared BUS_DATA/BUS_ADDR/BUS_WE bus, beside the other peripherals.

---
 rtl/bus_event_peripheral_pkg.sv | 28 ++
 rtl/bus_event_peripheral_evt_fifo.sv | 74 +++++++
 rtl/bus_event_peripheral.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bus_event_peripheral_pkg.sv
// Shared definitions for the bus event peripheral: register offsets,
// CONTROL/STATUS bit positions and the interrupt FSM encoding.
package bus_event_peripheral_pkg;

  localparam int CTRL_POP     = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;
  localparam int CTRL_IRQ_EN  = 7;

  localparam int STAT_OVF     = 7;
  localparam int STAT_EMPTY   = 6;
  localparam int STAT_COUNT_W = 6;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_RAISED   = 2'd1,
    IRQ_SERVICED = 2'd2
  } irq_state_e;

  function automatic logic [7:0] ofs_status(input int unsigned num_bytes);
    return 8'(num_bytes);
  endfunction

  function automatic logic [7:0] ofs_control(input int unsigned num_bytes);
    return 8'(num_bytes + 32'd1);
  endfunction

endpackage

// File: rtl/bus_event_peripheral_evt_fifo.sv
// Synchronous record FIFO with flush; head data is shown first-word-fall-through.
// push_acc_o/pop_acc_o report which requests were accepted (ignoring flush).
module evt_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       push_acc_o,
  output logic                       pop_acc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == {CW{1'b0}});
  assign count_o    = count_q;
  assign data_o     = mem_q[rd_ptr_q];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_acc_o = push_i & (~full_o | pop_i);
  assign pop_acc_o  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_acc_o) wr_ptr_d = wr_ptr_q + AW'(1);
      else            wr_ptr_d = wr_ptr_q;
      if (pop_acc_o)  rd_ptr_d = rd_ptr_q + AW'(1);
      else            rd_ptr_d = rd_ptr_q;
      case ({push_acc_o, pop_acc_o})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc_o && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bus_event_peripheral.sv
// Memory-mapped event peripheral: buffers event records in a FIFO, exposes head
// record/STATUS/CONTROL on the 8-bit bus and raises an acknowledged interrupt.
module bus_event_peripheral
  import bus_event_peripheral_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = 8'hA0,
  parameter int         NUM_BYTES     = 5,
  parameter int         DEPTH         = 4,
  parameter int         IRQ_THRESHOLD = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   EVT_VALID,
  input  logic [8*NUM_BYTES-1:0] EVT_DATA,
  inout  wire  [7:0]             BUS_DATA,
  input  logic [7:0]             BUS_ADDR,
  input  logic                   BUS_WE,
  output logic                   BUS_INTERRUPT_RAISE,
  input  logic                   BUS_INTERRUPT_ACK
);

  localparam int         CW          = $clog2(DEPTH) + 1;
  localparam logic [7:0] OFS_STATUS  = ofs_status(NUM_BYTES);
  localparam logic [7:0] OFS_CONTROL = ofs_control(NUM_BYTES);

  logic [8*NUM_BYTES-1:0] head_s;
  logic                   full_s, empty_s, push_acc_s, pop_acc_s;
  logic [CW-1:0]          count_s;
  logic [7:0]             off_s, rec_byte_s, rd_byte_s, status_s;
  logic                   in_win_s, rd_hit_s, ctrl_wr_s;
  logic                   pop_s, clr_ovf_s, flush_s, ovf_set_s, cond_s;
  logic                   ovf_q, ovf_d, irq_en_q, irq_en_d;
  logic                   drive_q, drive_d, raise_q, raise_d;
  logic [7:0]             out_q, out_d;
  irq_state_e             state_q, state_d;

  evt_fifo #(.WIDTH(8*NUM_BYTES), .DEPTH(DEPTH)) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .push_i     (EVT_VALID),
    .pop_i      (pop_s),
    .flush_i    (flush_s),
    .data_i     (EVT_DATA),
    .data_o     (head_s),
    .full_o     (full_s),
    .empty_o    (empty_s),
    .count_o    (count_s),
    .push_acc_o (push_acc_s),
    .pop_acc_o  (pop_acc_s)
  );

  assign off_s     = BUS_ADDR - BASE_ADDR;
  assign in_win_s  = (BUS_ADDR >= BASE_ADDR) && (off_s <= OFS_CONTROL);
  assign rd_hit_s  = in_win_s & ~BUS_WE;
  assign ctrl_wr_s = in_win_s & BUS_WE & (off_s == OFS_CONTROL);
  assign pop_s     = ctrl_wr_s & BUS_DATA[CTRL_POP];
  assign clr_ovf_s = ctrl_wr_s & BUS_DATA[CTRL_CLR_OVF];
  assign flush_s   = ctrl_wr_s & BUS_DATA[CTRL_FLUSH];
  // A rejected push is an overflow unless a flush is discarding it anyway.
  assign ovf_set_s = EVT_VALID & ~push_acc_s & ~flush_s;
  assign status_s  = {ovf_q, empty_s, STAT_COUNT_W'(count_s)};
  assign cond_s    = irq_en_q & ((count_s >= CW'(IRQ_THRESHOLD)) | ovf_q);

  assign BUS_DATA            = drive_q ? out_q : 8'hzz;
  assign BUS_INTERRUPT_RAISE = raise_q;

  always_comb begin
    rec_byte_s = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      rec_byte_s = (off_s == 8'(i)) ? head_s[8*i +: 8] : rec_byte_s;
    end
    rd_byte_s = 8'h00;
    if (off_s == OFS_STATUS)       rd_byte_s = status_s;
    else if (off_s == OFS_CONTROL) rd_byte_s = {irq_en_q, 7'b0000000};
    else if (!empty_s)             rd_byte_s = rec_byte_s;
    else                           rd_byte_s = 8'h00;
  end

  always_comb begin
    drive_d = rd_hit_s;
    out_d   = out_q;
    if (rd_hit_s) out_d = rd_byte_s;
    else          out_d = out_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr_s) irq_en_d = BUS_DATA[CTRL_IRQ_EN];
    else           irq_en_d = irq_en_q;
    ovf_d = ovf_q;
    if (ovf_set_s)      ovf_d = 1'b1;
    else if (clr_ovf_s) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  // Interrupt FSM; disabling interrupts forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (!irq_en_d) begin
      state_d = IRQ_IDLE;
    end else begin
      case (state_q)
        IRQ_IDLE:     if (cond_s) state_d = IRQ_RAISED;   else state_d = IRQ_IDLE;
        IRQ_RAISED:   if (BUS_INTERRUPT_ACK) state_d = IRQ_SERVICED;
                      else state_d = IRQ_RAISED;
        IRQ_SERVICED: if (push_acc_s | pop_acc_s | flush_s) state_d = IRQ_IDLE;
                      else state_d = IRQ_SERVICED;
        default:      state_d = IRQ_IDLE;
      endcase
    end
    raise_d = (state_d == IRQ_RAISED);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b1;
      drive_q  <= 1'b0;
      out_q    <= 8'h00;
      state_q  <= IRQ_IDLE;
      raise_q  <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      drive_q  <= drive_d;
      out_q    <= out_d;
      state_q  <= state_d;
      raise_q  <= raise_d;
    end
  end

endmodule
